// File: rtl/serial_comp_pkg.sv
// serial_comp_pkg
//   Shared definitions for the bit-serial magnitude comparator:
//   FSM state encodings and the one-hot {LG,EQ,RG} status constants.
package serial_comp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // One-hot status, bit order {LG, EQ, RG}
  localparam logic [2:0] ST_INIT = 3'b010;  // nothing seen yet: equal
  localparam logic [2:0] ST_LG   = 3'b100;  // X > Y
  localparam logic [2:0] ST_RG   = 3'b001;  // X < Y

endpackage

// File: rtl/serial_comp_cell.sv
// comp_cell
//   Combinational 1-bit compare cell. Bits arrive LSB-first, so a differing
//   bit simply overwrites the running status; later (higher) bits therefore
//   override everything decided below them.
// Ports
//   x, y       : current operand bits
//   status_in  : running {LG,EQ,RG} status from lower bits
//   status_out : updated status including this bit
module comp_cell
  import serial_comp_pkg::*;
(
  input  logic       x,
  input  logic       y,
  input  logic [2:0] status_in,
  output logic [2:0] status_out
);

  always_comb begin
    status_out = status_in;
    if (x && !y)      status_out = ST_LG;
    else if (!x && y) status_out = ST_RG;
  end

endmodule

// File: rtl/serial_comp.sv
// serial_comp
//   Bit-serial unsigned magnitude comparator. Operands are captured on a
//   valid/ready accept, walked LSB-first through one comp_cell per clock,
//   and the one-hot result is presented under a valid/ack handshake.
//   Latency is WIDTH cycles from accept to VALID_OUT, independent of data.
// Ports
//   CLK, RST_N      : clock (rising edge), async active-low reset
//   START_IN        : operand valid, accepted while READY_OUT=1
//   READY_OUT       : high only in IDLE
//   X_IN, Y_IN      : unsigned operands, sampled on accept
//   VALID_OUT       : result valid, held until ACK_IN
//   ACK_IN          : consumer takes result
//   LG/EQ/RG_OUT    : X>Y / X==Y / X<Y, updated only when a result completes
module serial_comp
  import serial_comp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START_IN,
  output logic             READY_OUT,
  input  logic [WIDTH-1:0] X_IN,
  input  logic [WIDTH-1:0] Y_IN,
  output logic             VALID_OUT,
  input  logic             ACK_IN,
  output logic             LG_OUT,
  output logic             EQ_OUT,
  output logic             RG_OUT
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] xs, ys;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       status, status_nxt;

  comp_cell u_cell (
    .x          (xs[0]),
    .y          (ys[0]),
    .status_in  (status),
    .status_out (status_nxt)
  );

  assign READY_OUT = (state == S_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      xs        <= '0;
      ys        <= '0;
      cnt       <= '0;
      status    <= '0;
      VALID_OUT <= 1'b0;
      LG_OUT    <= 1'b0;
      EQ_OUT    <= 1'b0;
      RG_OUT    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START_IN) begin
            xs     <= X_IN;
            ys     <= Y_IN;
            status <= ST_INIT;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          status <= status_nxt;
          xs     <= xs >> 1;
          ys     <= ys >> 1;
          cnt    <= cnt + CNT_W'(1);
          // Last bit: publish the final status straight from the cell so the
          // result lands on the same edge the FSM enters HOLD.
          if (cnt == CNT_LAST) begin
            state                    <= S_HOLD;
            VALID_OUT                <= 1'b1;
            {LG_OUT, EQ_OUT, RG_OUT} <= status_nxt;
          end
        end
        S_HOLD: begin
          if (ACK_IN) begin
            state     <= S_IDLE;
            VALID_OUT <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          VALID_OUT <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comp.sv
// tb_serial_comp
//   Directed bench for serial_comp: reset, basic compares, MSB override,
//   HOLD back-pressure, mid-RUN reset, exhaustive WIDTH=4 and random
//   sweeps at WIDTH=1 and WIDTH=8 with latency checks on every op.
module tb_serial_comp;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N;

  logic       start4, ready4, valid4, ack4, lg4, eq4, rg4;
  logic [3:0] x4, y4;
  logic       start1, ready1, valid1, ack1, lg1, eq1, rg1;
  logic [0:0] x1, y1;
  logic       start8, ready8, valid8, ack8, lg8, eq8, rg8;
  logic [7:0] x8, y8;

  int n_tests = 0;
  int n_fail  = 0;

  serial_comp #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .START_IN(start4), .READY_OUT(ready4),
    .X_IN(x4), .Y_IN(y4), .VALID_OUT(valid4), .ACK_IN(ack4),
    .LG_OUT(lg4), .EQ_OUT(eq4), .RG_OUT(rg4));

  serial_comp #(.WIDTH(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .START_IN(start1), .READY_OUT(ready1),
    .X_IN(x1), .Y_IN(y1), .VALID_OUT(valid1), .ACK_IN(ack1),
    .LG_OUT(lg1), .EQ_OUT(eq1), .RG_OUT(rg1));

  serial_comp #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .START_IN(start8), .READY_OUT(ready8),
    .X_IN(x8), .Y_IN(y8), .VALID_OUT(valid8), .ACK_IN(ack8),
    .LG_OUT(lg8), .EQ_OUT(eq8), .RG_OUT(rg8));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One WIDTH=4 operation: accept, measure latency, check result, ack.
  task automatic op4(input logic [3:0] x, input logic [3:0] y,
                     input logic [2:0] exp, input string nm);
    int n;
    n = 0;
    while (!ready4 && n < 20) begin tick(); n++; end
    x4 = x; y4 = y; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    x4 = ~x; y4 = ~y;  // operands must have been sampled already
    n_tests++;
    if (ready4 !== 1'b0) begin
      n_fail++; $display("FAIL %s ready_after_accept got %b exp 0", nm, ready4);
    end
    n = 0;
    while (!valid4 && n < 20) begin tick(); n++; end
    n_tests++;
    if (n != 4) begin
      n_fail++; $display("FAIL %s latency got %0d exp 4", nm, n);
    end
    n_tests++;
    if ({lg4, eq4, rg4} !== exp) begin
      n_fail++; $display("FAIL %s result got %b exp %b", nm, {lg4, eq4, rg4}, exp);
    end
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    n_tests++;
    if (valid4 !== 1'b0 || ready4 !== 1'b1) begin
      n_fail++; $display("FAIL %s after_ack valid=%b ready=%b exp 0/1", nm, valid4, ready4);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    start4 = 0; ack4 = 0; x4 = '0; y4 = '0;
    start1 = 0; ack1 = 0; x1 = '0; y1 = '0;
    start8 = 0; ack8 = 0; x8 = '0; y8 = '0;
    repeat (3) tick();
    n_tests++;
    if (ready4 !== 1'b1 || valid4 !== 1'b0 || {lg4, eq4, rg4} !== 3'b000) begin
      n_fail++; $display("FAIL reset_hold ready=%b valid=%b res=%b exp 1/0/000",
                         ready4, valid4, {lg4, eq4, rg4});
    end
    RST_N = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (ready4 !== 1'b1 || valid4 !== 1'b0 || {lg4, eq4, rg4} !== 3'b000) begin
      n_fail++; $display("FAIL reset_release ready=%b valid=%b res=%b exp 1/0/000",
                         ready4, valid4, {lg4, eq4, rg4});
    end
  endtask

  task automatic test_basic();
    op4(4'hA, 4'h6, 3'b100, "basic_a_gt_6");
    op4(4'h5, 4'h5, 3'b010, "basic_5_eq_5");
    op4(4'h3, 4'hC, 3'b001, "basic_3_lt_c");
  endtask

  task automatic test_msb_override();
    op4(4'h8, 4'h7, 3'b100, "msb_8_gt_7");
    op4(4'h7, 4'h8, 3'b001, "msb_7_lt_8");
    op4(4'h0, 4'h0, 3'b010, "zero_eq");
    op4(4'hF, 4'h0, 3'b100, "max_gt_zero");
  endtask

  task automatic test_hold();
    int n;
    int bad;
    x4 = 4'h2; y4 = 4'h9; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    while (!valid4 && n < 20) begin tick(); n++; end
    n_tests++;
    if (n != 4 || {lg4, eq4, rg4} !== 3'b001) begin
      n_fail++; $display("FAIL hold_setup latency=%0d res=%b exp 4/001", n, {lg4, eq4, rg4});
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      start4 = 1'b1; x4 = 4'($urandom); y4 = 4'($urandom);
      tick();
      n_tests++;
      if (ready4 !== 1'b0 || valid4 !== 1'b1 || {lg4, eq4, rg4} !== 3'b001) begin
        n_fail++; bad++;
        $display("FAIL hold_cycle%0d ready=%b valid=%b res=%b exp 0/1/001",
                 i, ready4, valid4, {lg4, eq4, rg4});
      end
    end
    start4 = 1'b0;
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    n_tests++;
    if (valid4 !== 1'b0 || ready4 !== 1'b1 || {lg4, eq4, rg4} !== 3'b001) begin
      n_fail++; $display("FAIL hold_ack valid=%b ready=%b res=%b exp 0/1/001",
                         valid4, ready4, {lg4, eq4, rg4});
    end
    // Starts pulsed during HOLD must not have been queued
    repeat (6) tick();
    n_tests++;
    if (valid4 !== 1'b0 || ready4 !== 1'b1) begin
      n_fail++; $display("FAIL hold_no_queue valid=%b ready=%b exp 0/1", valid4, ready4);
    end
    // Ack outside HOLD is ignored
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    n_tests++;
    if (valid4 !== 1'b0 || ready4 !== 1'b1) begin
      n_fail++; $display("FAIL stray_ack valid=%b ready=%b exp 0/1", valid4, ready4);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    // Previous result still shows 001 here, so 000 below proves the clear
    x4 = 4'h5; y4 = 4'h3; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    RST_N = 1'b0;
    #1;
    n_tests++;
    if (ready4 !== 1'b1 || valid4 !== 1'b0 || {lg4, eq4, rg4} !== 3'b000) begin
      n_fail++; $display("FAIL midrun_reset ready=%b valid=%b res=%b exp 1/0/000",
                         ready4, valid4, {lg4, eq4, rg4});
    end
    repeat (2) tick();
    RST_N = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid4 !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midrun_no_valid valid_cycles=%0d exp 0", seen);
    end
    op4(4'h9, 4'h9, 3'b010, "after_reset_9_eq_9");
  endtask

  task automatic test_exhaustive4();
    logic [2:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp = {a > b, a == b, a < b};
        op4(4'(a), 4'(b), exp, $sformatf("exh_%0d_%0d", a, b));
      end
    end
  endtask

  task automatic test_width1();
    int n;
    logic [0:0] a, b;
    logic [2:0] exp;
    for (int i = 0; i < 24; i++) begin
      a = (i < 4) ? 1'(i >> 1) : 1'($urandom_range(0, 1));
      b = (i < 4) ? 1'(i)      : 1'($urandom_range(0, 1));
      exp = {a > b, a == b, a < b};
      n = 0;
      while (!ready1 && n < 20) begin tick(); n++; end
      x1 = a; y1 = b; start1 = 1'b1;
      tick();
      start1 = 1'b0; x1 = ~a; y1 = ~b;
      n = 0;
      while (!valid1 && n < 20) begin tick(); n++; end
      n_tests++;
      if (n != 1 || {lg1, eq1, rg1} !== exp) begin
        n_fail++; $display("FAIL w1_%0d_%0d latency=%0d res=%b exp 1/%b",
                           a, b, n, {lg1, eq1, rg1}, exp);
      end
      ack1 = 1'b1;
      tick();
      ack1 = 1'b0;
    end
  endtask

  task automatic test_width8();
    int n;
    logic [7:0] a, b;
    logic [2:0] exp;
    for (int i = 0; i < 40; i++) begin
      case (i)
        0: begin a = 8'h80; b = 8'h7F; end
        1: begin a = 8'h7F; b = 8'h80; end
        2: begin a = 8'hFF; b = 8'hFF; end
        3: begin a = 8'h00; b = 8'h01; end
        default: begin
          a = 8'($urandom);
          b = (i % 5 == 0) ? a : 8'($urandom);
        end
      endcase
      exp = {a > b, a == b, a < b};
      n = 0;
      while (!ready8 && n < 20) begin tick(); n++; end
      x8 = a; y8 = b; start8 = 1'b1;
      tick();
      start8 = 1'b0; x8 = ~a; y8 = ~b;
      n = 0;
      while (!valid8 && n < 30) begin tick(); n++; end
      n_tests++;
      if (n != 8 || {lg8, eq8, rg8} !== exp) begin
        n_fail++; $display("FAIL w8_%0h_%0h latency=%0d res=%b exp 8/%b",
                           a, b, n, {lg8, eq8, rg8}, exp);
      end
      ack8 = 1'b1;
      tick();
      ack8 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb_override();
    test_hold();
    test_reset_mid_run();
    test_exhaustive4();
    test_width1();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
